// File: rtl/cmp_pipe_nbit.sv
// Pipelined WIDTH-bit magnitude comparator with an equality tolerance window,
// a two-stage valid/ready pipeline and saturating per-outcome event counters.
module cmp_pipe_nbit #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   ain,
  input  logic [WIDTH-1:0]   bin,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   tol,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               a_greater,
  output logic               a_b_equal,
  output logic               b_greater,
  output logic [WIDTH:0]     diff,
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] cnt_gt,
  output logic [COUNT_W-1:0] cnt_eq,
  output logic [COUNT_W-1:0] cnt_lt
);

  localparam int DW = WIDTH + 1;

  logic             s1_valid;
  logic [DW-1:0]    s1_a;
  logic [DW-1:0]    s1_b;
  logic [WIDTH-1:0] s1_tol;

  logic             s2_adv;
  logic             s1_adv;
  logic             out_hs;

  logic [DW-1:0]    a_ext;
  logic [DW-1:0]    b_ext;
  logic [DW-1:0]    s1_d;
  logic [DW-1:0]    s1_d_neg;
  logic [WIDTH-1:0] s1_mag;
  logic             s1_eq;
  logic             s1_gt;
  logic             s1_lt;

  // Flow control: a stage may load when it is empty or its contents leave.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign out_hs   = out_valid && out_ready;

  // The mode bit is folded into the extension at capture time, so each beat
  // carries its own signedness into the subtraction.
  assign a_ext = {signed_mode & ain[WIDTH-1], ain};
  assign b_ext = {signed_mode & bin[WIDTH-1], bin};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the pipeline stages do not race each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tol   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= a_ext;
        s1_b   <= b_ext;
        s1_tol <= tol;
      end
    end
  end

  // Both operands fit in WIDTH+1 bits after extension, so the difference
  // cannot overflow and |d| always fits back into WIDTH bits.
  assign s1_d     = s1_a - s1_b;
  assign s1_d_neg = '0 - s1_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    s1_mag = s1_d[WIDTH-1:0];
    if (s1_d[DW-1]) begin
      s1_mag = s1_d_neg[WIDTH-1:0];
    end
  end

  // d == 0 always lands in the equal bucket, so outside the window the sign
  // bit alone separates A > B from B > A.
  assign s1_eq = (s1_mag <= s1_tol);
  assign s1_gt = !s1_eq && !s1_d[DW-1];
  assign s1_lt = !s1_eq &&  s1_d[DW-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      a_greater <= 1'b0;
      a_b_equal <= 1'b0;
      b_greater <= 1'b0;
      diff      <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        a_greater <= s1_gt;
        a_b_equal <= s1_eq;
        b_greater <= s1_lt;
        diff      <= s1_d;
      end
    end
  end

  // Clear has priority over a coincident handshake; counts stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_gt <= '0;
      cnt_eq <= '0;
      cnt_lt <= '0;
    end else if (cnt_clr) begin
      cnt_gt <= '0;
      cnt_eq <= '0;
      cnt_lt <= '0;
    end else if (out_hs) begin
      if (a_greater && (cnt_gt != '1)) cnt_gt <= cnt_gt + 1'b1;
      if (a_b_equal && (cnt_eq != '1)) cnt_eq <= cnt_eq + 1'b1;
      if (b_greater && (cnt_lt != '1)) cnt_lt <= cnt_lt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cmp_pipe_nbit.sv
// Scoreboard bench for cmp_pipe_nbit: expected results are queued as beats are
// accepted and compared by a monitor as result handshakes occur.
module tb_cmp_pipe_nbit;

  localparam int W     = 8;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct {
    logic         gt;
    logic         eq;
    logic         lt;
    logic [W:0]   diff;
  } res_t;

  logic          clk;
  logic          rst;
  logic [W-1:0]  ain;
  logic [W-1:0]  bin;
  logic          signed_mode;
  logic [W-1:0]  tol;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          a_greater;
  logic          a_b_equal;
  logic          b_greater;
  logic [W:0]    diff;
  logic          cnt_clr;
  logic [CW-1:0] cnt_gt;
  logic [CW-1:0] cnt_eq;
  logic [CW-1:0] cnt_lt;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_pop = 0;
  int   prev_pop = 0;
  int   m_gt = 0;
  int   m_eq = 0;
  int   m_lt = 0;
  res_t sb_q[$];

  cmp_pipe_nbit #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ain(ain), .bin(bin), .signed_mode(signed_mode),
    .tol(tol), .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .a_greater(a_greater), .a_b_equal(a_b_equal),
    .b_greater(b_greater), .diff(diff), .cnt_clr(cnt_clr), .cnt_gt(cnt_gt),
    .cnt_eq(cnt_eq), .cnt_lt(cnt_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sm, input logic [W-1:0] t);
    res_t r;
    int av, bv, d, mag;
    av = sm ? int'($signed(a)) : int'(a);
    bv = sm ? int'($signed(b)) : int'(b);
    d   = av - bv;
    mag = (d < 0) ? -d : d;
    r.eq   = (mag <= int'(t));
    r.gt   = !r.eq && (d > 0);
    r.lt   = !r.eq && (d < 0);
    r.diff = d[W:0];
    return r;
  endfunction

  // Monitor: counter model check, then scoreboard compare on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      m_gt = 0; m_eq = 0; m_lt = 0;
    end else begin
      checks++;
      if (int'(cnt_gt) != m_gt || int'(cnt_eq) != m_eq || int'(cnt_lt) != m_lt) begin
        errors++;
        $display("FAIL counters: got gt=%0d eq=%0d lt=%0d expected gt=%0d eq=%0d lt=%0d",
                 cnt_gt, cnt_eq, cnt_lt, m_gt, m_eq, m_lt);
      end
      if (out_valid && out_ready) begin
        res_t e;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got diff=%h with empty scoreboard", diff);
        end else begin
          e = sb_q.pop_front();
          prev_pop = last_pop;
          last_pop = cyc;
          if (a_greater !== e.gt || a_b_equal !== e.eq || b_greater !== e.lt || diff !== e.diff) begin
            errors++;
            $display("FAIL result: got gt=%b eq=%b lt=%b diff=%h expected gt=%b eq=%b lt=%b diff=%h",
                     a_greater, a_b_equal, b_greater, diff, e.gt, e.eq, e.lt, e.diff);
          end
          if (cnt_clr) begin
            m_gt = 0; m_eq = 0; m_lt = 0;
          end else begin
            if (e.gt && m_gt < CMAX) m_gt++;
            if (e.eq && m_eq < CMAX) m_eq++;
            if (e.lt && m_lt < CMAX) m_lt++;
          end
        end
      end else if (cnt_clr) begin
        m_gt = 0; m_eq = 0; m_lt = 0;
      end
    end
  end

  // Offers one beat and returns at posedge+1 right after it is accepted.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sm, input logic [W-1:0] t);
    bit done = 0;
    ain = a; bin = b; signed_mode = sm; tol = t; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(model(a, b, sm, t));
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: beat a=%h b=%h not accepted within 50 cycles", a, b);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== '0 ||
        {a_greater, a_b_equal, b_greater} !== 3'b000 ||
        cnt_gt !== '0 || cnt_eq !== '0 || cnt_lt !== '0) begin
      errors++;
      $display("FAIL reset_state: got ov=%b ir=%b flags=%b%b%b diff=%h cnt=%0d/%0d/%0d expected ov=0 ir=1 all else 0",
               out_valid, in_ready, a_greater, a_b_equal, b_greater, diff, cnt_gt, cnt_eq, cnt_lt);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_unsigned();
    send(8'h03, 8'h0C, 1'b0, 8'h00);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_1cyc: got out_valid=%b expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_2cyc: got out_valid=%b expected 1", out_valid);
    end
    @(posedge clk); #1;
    send(8'h0C, 8'h0C, 1'b0, 8'h00);
    drain();
  endtask

  task automatic test_mode_switch();
    send(8'hFF, 8'h01, 1'b1, 8'h00);
    send(8'hFF, 8'h01, 1'b0, 8'h00);
    drain();
    checks++;
    if (last_pop - prev_pop != 1) begin
      errors++;
      $display("FAIL mode_consecutive: got result gap %0d cycles expected 1", last_pop - prev_pop);
    end
  endtask

  task automatic test_tolerance();
    send(8'd100, 8'd103, 1'b0, 8'd3);
    send(8'd100, 8'd103, 1'b0, 8'd2);
    send(8'h80, 8'h7F, 1'b1, 8'd0);
    send(8'h00, 8'hFF, 1'b0, 8'hFF);
    send(8'h80, 8'h7F, 1'b1, 8'hFF);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 8)));
    drain();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ba [3] = '{8'd10, 8'd200, 8'd7};
    logic [W-1:0] bb [3] = '{8'd20, 8'd5, 8'd7};
    logic [W+3:0] snap;
    int idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 3) begin
        ain = ba[idx]; bin = bb[idx]; signed_mode = 1'b0; tol = 8'd0; in_valid = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb_q.push_back(model(ba[idx], bb[idx], 1'b0, 8'd0));
        idx++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (idx != 2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: got accepted=%0d in_ready=%b expected accepted=2 in_ready=0", idx, in_ready);
    end
    snap = {a_greater, a_b_equal, b_greater, diff};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || {a_greater, a_b_equal, b_greater, diff} !== snap) begin
        errors++;
        $display("FAIL bp_stable: got ov=%b out=%h expected ov=1 out=%h", out_valid,
                 {a_greater, a_b_equal, b_greater, diff}, snap);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && idx < 3; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(model(ba[idx], bb[idx], 1'b0, 8'd0));
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 3) begin
      errors++;
      $display("FAIL bp_third_beat: got accepted=%0d expected 3", idx);
    end
    drain();
  endtask

  task automatic test_counters();
    bit seen = 0;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 17; i++) send(8'd50, 8'd10, 1'b0, 8'd0);
    drain();
    checks++;
    if (cnt_gt !== 4'd15 || cnt_eq !== 4'd0 || cnt_lt !== 4'd0) begin
      errors++;
      $display("FAIL cnt_saturate: got gt=%0d eq=%0d lt=%0d expected gt=15 eq=0 lt=0", cnt_gt, cnt_eq, cnt_lt);
    end
    send(8'd1, 8'd1, 1'b0, 8'd0);
    for (int i = 0; i < 10 && !seen; i++) begin
      if (out_valid) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (!seen || cnt_gt !== '0 || cnt_eq !== '0 || cnt_lt !== '0) begin
      errors++;
      $display("FAIL cnt_clr_wins: got seen=%b gt=%0d eq=%0d lt=%0d expected seen=1 all 0", seen, cnt_gt, cnt_eq, cnt_lt);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    send(8'd9, 8'd3, 1'b0, 8'd0);
    drain();
    out_ready = 1'b0;
    send(8'd9, 8'd3, 1'b0, 8'd0);
    send(8'd1, 8'd2, 1'b0, 8'd0);
    #3 rst = 1'b1;
    #1;
    sb_q.delete();
    m_gt = 0; m_eq = 0; m_lt = 0;
    checks++;
    if (out_valid !== 1'b0 || {a_greater, a_b_equal, b_greater} !== 3'b000 || diff !== '0 ||
        cnt_gt !== '0 || cnt_eq !== '0 || cnt_lt !== '0) begin
      errors++;
      $display("FAIL mid_reset: got ov=%b flags=%b%b%b diff=%h cnt=%0d/%0d/%0d expected all 0",
               out_valid, a_greater, a_b_equal, b_greater, diff, cnt_gt, cnt_eq, cnt_lt);
    end
    #2 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(8'd5, 8'd5, 1'b0, 8'd0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_lat1: got out_valid=%b expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || a_b_equal !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_lat2: got ov=%b eq=%b expected ov=1 eq=1", out_valid, a_b_equal);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (cnt_eq !== 4'd1 || cnt_gt !== '0 || cnt_lt !== '0) begin
      errors++;
      $display("FAIL post_reset_cnt: got gt=%0d eq=%0d lt=%0d expected gt=0 eq=1 lt=0", cnt_gt, cnt_eq, cnt_lt);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; ain = '0; bin = '0; signed_mode = 1'b0; tol = '0;
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    test_reset();
    @(posedge clk); #1;
    test_unsigned();
    test_mode_switch();
    test_tolerance();
    test_back_to_back();
    test_backpressure();
    test_counters();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_pipe_nbit.md
Name: cmp_pipe_nbit

Overview:
Parametrised, pipelined magnitude comparator that succeeds the fixed 4-bit combinational comparator. It compares two WIDTH-bit operands in either unsigned or two's-complement mode, with a programmable equality tolerance window. Results travel through a 2-stage valid/ready pipeline with backpressure. Per-outcome saturating event counters track the results. It sits between a sample source and downstream decision logic.

Parameters:
WIDTH, 8, operand width in bits (>=2)
COUNT_W, 16, width of each outcome event counter (>=2)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
ain  input  WIDTH  operand A
bin  input  WIDTH  operand B
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with the operands
tol  input  WIDTH  unsigned equality tolerance; sampled with the operands
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts the result
a_greater  output  1  A > B beyond tolerance
a_b_equal  output  1  |A-B| <= tol
b_greater  output  1  B > A beyond tolerance
diff  output  WIDTH+1  signed A-B, full precision
cnt_clr  input  1  synchronous clear of all counters
cnt_gt  output  COUNT_W  count of accepted a_greater results
cnt_eq  output  COUNT_W  count of accepted a_b_equal results
cnt_lt  output  COUNT_W  count of accepted b_greater results

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. While rst=1, all pipeline valids, result outputs, diff and counters are 0; in_ready reads 1.
- Input accept: a beat is accepted when in_valid && in_ready.
- Stage 1 (S1): on accept, registers ain, bin, signed_mode and tol. It extends each operand to WIDTH+1 bits, sign-extending if signed_mode=1 and zero-extending otherwise, and computes d = A_ext - B_ext in WIDTH+1 bits. This subtraction never overflows.
- Stage 2 (S2, the output register): computes mag = |d| (WIDTH bits; the maximum value is 2^WIDTH-1, which fits). It then classifies the result:
  - a_b_equal = (mag <= tol)
  - otherwise a_greater = (d > 0) and b_greater = (d < 0)
  - Exactly one flag is 1 whenever out_valid=1.
  - diff = d.
- Latency: 2 cycles from accept to out_valid when there is no stall. Throughput is 1 beat/cycle.
- Flow control:
  - s2_adv = !out_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational, no in_valid dependence)
  - S1 moves to S2 when s1_valid && s2_adv.
  - out_valid clears on a handshake if no new S1 data arrives.
  - Beats are never dropped or duplicated, and order is preserved.
- Output stability: while out_valid && !out_ready, the flags and diff hold stable.
- Counters:
  - On a result handshake (out_valid && out_ready), the counter matching the presented flag increments by 1.
  - Counters saturate at 2^COUNT_W-1 and never wrap.
  - cnt_clr=1 zeroes all three counters on the next edge. If cnt_clr coincides with a handshake, the clear wins and the counter ends at 0.
- Mid-operation reset: in-flight beats are discarded; after rst deasserts, the first result comes from the first beat accepted after reset.
- Mode per beat: signed_mode and tol may change every beat. Each result uses the values captured with its own operands.
- Tolerance edge cases: tol=0 gives an exact compare. tol=2^WIDTH-1 makes every result equal.

Test Plan:
- Unsigned exact compare, WIDTH=8, signed_mode=0, tol=0:
  - ain=0x03, bin=0x0C -> b_greater=1, diff=9'h1F7 (-9), out_valid exactly 2 cycles after accept.
  - ain=0x0C, bin=0x0C -> a_b_equal=1, diff=0.
- Mode switch, back-to-back beats with ain=0xFF, bin=0x01:
  - signed_mode=1 -> b_greater=1, diff=-2.
  - signed_mode=0 -> a_greater=1, diff=+254.
  - The two results emerge on consecutive cycles.
- Tolerance window, ain=100, bin=103:
  - tol=3 -> a_b_equal=1.
  - tol=2 -> b_greater=1.
  - Signed ain=-128, bin=127, tol=0 -> b_greater=1, diff=-255.
- Backpressure: hold out_ready=0 and offer 3 continuous beats.
  - Exactly 2 are accepted and in_ready drops to 0.
  - The output holds stable for 4 stalled cycles.
  - After raising out_ready, all 3 results arrive in order with none lost.
- Counters, COUNT_W=4: 17 accepted a_greater results -> cnt_gt=15 (saturated), cnt_eq=cnt_lt=0. Asserting cnt_clr on the same cycle as a handshake -> all counters read 0 next cycle.
- Mid-operation reset: assert rst asynchronously, between edges, while both stages are full.
  - out_valid, flags, diff and counters go to 0 immediately.
  - After release, a fresh beat ain=5, bin=5 -> a_b_equal=1 after 2 cycles and cnt_eq=1 once accepted.
